// File: rtl/ssm_tile_feeder.sv
// Holds one head's B/C/h_prev vectors plus dt/dA/x/D scalars, loaded by word
// writes, and streams the vectors as N_TILE-wide tiles over valid/ready.
module ssm_tile_feeder #(
  parameter int DW      = 16,
  parameter int N_TOTAL = 128,
  parameter int N_TILE  = 16,
  localparam int TILES  = N_TOTAL / N_TILE,
  localparam int AW     = (N_TOTAL > 1) ? $clog2(N_TOTAL) : 1,
  localparam int IW     = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [1:0]           wr_sel_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [DW-1:0]        wr_data_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tile_valid_o,
  input  logic                 tile_ready_i,
  output logic [IW-1:0]        tile_idx_o,
  output logic                 tile_last_o,
  output logic [DW-1:0]        dt_o,
  output logic [DW-1:0]        dA_o,
  output logic [DW-1:0]        x_o,
  output logic [DW-1:0]        D_o,
  output logic [N_TILE*DW-1:0] B_tile_o,
  output logic [N_TILE*DW-1:0] C_tile_o,
  output logic [N_TILE*DW-1:0] hprev_tile_o
);

  localparam logic [IW-1:0] LAST_IDX = IW'(TILES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          handshake;
  logic          wr_ok;

  logic [DW-1:0] b_mem [N_TOTAL];
  logic [DW-1:0] c_mem [N_TOTAL];
  logic [DW-1:0] h_mem [N_TOTAL];
  logic [DW-1:0] dt_reg, da_reg, x_reg, d_reg;

  assign handshake = tile_valid_o && tile_ready_i;
  assign wr_ok     = wr_en_i && (state_reg == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = STREAM;
          idx_next   = '0;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (idx_reg == LAST_IDX) state_next = DONE;
          else                     idx_next   = idx_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_o       = (state_reg != IDLE);
  assign done_o       = (state_reg == DONE);
  assign tile_valid_o = (state_reg == STREAM);
  assign tile_last_o  = tile_valid_o && (idx_reg == LAST_IDX);

  // Storage is cleared on reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TOTAL; i++) begin
        b_mem[i] <= '0;
        c_mem[i] <= '0;
        h_mem[i] <= '0;
      end
      dt_reg <= '0;
      da_reg <= '0;
      x_reg  <= '0;
      d_reg  <= '0;
    end else if (wr_ok) begin
      case (wr_sel_i)
        2'd0: b_mem[wr_addr_i] <= wr_data_i;
        2'd1: c_mem[wr_addr_i] <= wr_data_i;
        2'd2: h_mem[wr_addr_i] <= wr_data_i;
        default: begin
          case (wr_addr_i[1:0])
            2'd0:    dt_reg <= wr_data_i;
            2'd1:    da_reg <= wr_data_i;
            2'd2:    x_reg  <= wr_data_i;
            default: d_reg  <= wr_data_i;
          endcase
        end
      endcase
    end
  end

  assign tile_idx_o = tile_valid_o ? idx_reg : '0;
  assign dt_o       = tile_valid_o ? dt_reg  : '0;
  assign dA_o       = tile_valid_o ? da_reg  : '0;
  assign x_o        = tile_valid_o ? x_reg   : '0;
  assign D_o        = tile_valid_o ? d_reg   : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_TILE; gi++) begin : g_lane
      logic [AW-1:0] rd_addr;
      assign rd_addr = AW'(int'(idx_reg) * N_TILE + gi);
      assign B_tile_o[DW*gi +: DW]     = tile_valid_o ? b_mem[rd_addr] : '0;
      assign C_tile_o[DW*gi +: DW]     = tile_valid_o ? c_mem[rd_addr] : '0;
      assign hprev_tile_o[DW*gi +: DW] = tile_valid_o ? h_mem[rd_addr] : '0;
    end
  endgenerate

endmodule
